// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter controller with program launch, jump/branch,
// memory-wait stall, halt detection and a saturating per-program cycle counter.
module pc_sequencer #(
    parameter logic [15:0] PROG0_BASE = 16'd0,
    parameter logic [15:0] PROG1_BASE = 16'd3,
    parameter logic [15:0] PROG2_BASE = 16'd5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  prog_sel,
    input  logic [3:0]  opcode,
    input  logic [15:0] target,
    input  logic        flag_eq,
    input  logic        flag_lt,
    input  logic        mem_ready,
    output logic [15:0] pc,
    output logic        running,
    output logic        commit,
    output logic        mem_req,
    output logic        done,
    output logic [15:0] cycles
);
    localparam logic [3:0] OP_LB = 4'b0000, OP_LHB = 4'b0001, OP_JMP = 4'b0010,
                           OP_STR = 4'b0011, OP_BNE = 4'b1010, OP_BEQ = 4'b1011,
                           OP_BLT = 4'b1100, OP_HALT = 4'b1110;

    typedef enum logic [1:0] {IDLE, RUN, MEM_WAIT, HALTED} state_t;
    state_t state;

    logic        is_mem, take, launch;
    logic [15:0] base;

    assign is_mem  = opcode == OP_LB || opcode == OP_LHB || opcode == OP_STR;
    assign take    = opcode == OP_JMP || (opcode == OP_BNE && !flag_eq) ||
                     (opcode == OP_BEQ && flag_eq) || (opcode == OP_BLT && flag_lt);
    assign running = state == RUN || state == MEM_WAIT;
    assign mem_req = state == MEM_WAIT || (state == RUN && is_mem);
    assign commit  = (state == RUN && (!is_mem || mem_ready)) || (state == MEM_WAIT && mem_ready);
    assign launch  = (state == IDLE || state == HALTED) && start && prog_sel != 2'd3;
    assign base    = prog_sel == 2'd0 ? PROG0_BASE : prog_sel == 2'd1 ? PROG1_BASE : PROG2_BASE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            pc     <= 16'd0;
            cycles <= 16'd0;
            done   <= 1'b0;
        end else begin
            done <= state == RUN && opcode == OP_HALT;
            if (running && cycles != 16'hFFFF) cycles <= cycles + 16'd1;
            if (launch) begin
                pc     <= base;
                cycles <= 16'd0;
                state  <= RUN;
            end else if (state == RUN) begin
                if (opcode == OP_HALT) state <= HALTED;
                else if (is_mem && !mem_ready) state <= MEM_WAIT;
                else pc <= take ? target : pc + 16'd1;
            end else if (state == MEM_WAIT && mem_ready) begin
                pc    <= pc + 16'd1;
                state <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scenario tasks drive per-cycle steps; expected outputs are
// queued at drive time and popped for comparison once the edge has happened.
module tb_pc_sequencer;
    logic        clk = 0, reset = 0, start = 0, flag_eq = 0, flag_lt = 0, mem_ready = 0;
    logic [1:0]  prog_sel = 0;
    logic [3:0]  opcode = 4'h4;
    logic [15:0] target = 0;
    logic [15:0] pc, cycles;
    logic        running, commit, mem_req, done;
    int          npass = 0, ntot = 0;

    localparam logic [3:0] LB = 4'h0, LHB = 4'h1, JMP = 4'h2, STR = 4'h3, NOP = 4'h4,
                           BNE = 4'hA, BEQ = 4'hB, BLT = 4'hC, HLT = 4'hE;

    typedef struct packed {
        logic [3:0]  op;
        logic [15:0] tgt;
        logic        eq, lt, rdy, st;
        logic [1:0]  sel;
        logic [1:0]  cm;
        logic [15:0] pc;
        logic        run, done;
    } step_t;

    logic [19:0] sb[$];
    logic [1:0]  cm_obs;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .prog_sel(prog_sel), .opcode(opcode),
        .target(target), .flag_eq(flag_eq), .flag_lt(flag_lt), .mem_ready(mem_ready),
        .pc(pc), .running(running), .commit(commit), .mem_req(mem_req), .done(done),
        .cycles(cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Applies one cycle of stimulus; {commit,mem_req} is captured before the edge.
    task automatic drive(input step_t s);
        opcode = s.op; target = s.tgt; flag_eq = s.eq; flag_lt = s.lt;
        mem_ready = s.rdy; start = s.st; prog_sel = s.sel;
        sb.push_back({s.cm, s.pc, s.run, s.done});
        #1;
        cm_obs = {commit, mem_req};
        tick();
        start = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        tick();
        tick();
        reset = 0;
        ntot++;
        if ({pc, cycles, running, commit, mem_req, done} !== 36'd0)
            $display("FAIL reset: got pc=%h cycles=%h run=%b cm=%b mr=%b done=%b want all 0",
                     pc, cycles, running, commit, mem_req, done);
        else npass++;
    endtask

    task automatic test_program;
        step_t t[5] = '{
            '{NOP, 16'h0, 0, 0, 0, 1, 2'd1, 2'b00, 16'h0003, 1, 0},
            '{NOP, 16'h0, 0, 0, 0, 0, 2'd0, 2'b10, 16'h0004, 1, 0},
            '{NOP, 16'h0, 0, 0, 0, 0, 2'd0, 2'b10, 16'h0005, 1, 0},
            '{HLT, 16'h0, 0, 0, 0, 0, 2'd0, 2'b10, 16'h0005, 0, 1},
            '{NOP, 16'h0, 0, 0, 0, 1, 2'd3, 2'b00, 16'h0005, 0, 0}
        };
        logic [19:0] e;
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            ntot++;
            if ({cm_obs, pc, running, done} !== e)
                $display("FAIL program step %0d: got %h want %h", i, {cm_obs, pc, running, done}, e);
            else npass++;
        end
        ntot++;
        if (cycles !== 16'd3) $display("FAIL program_cycles: got %h want 0003", cycles);
        else npass++;
    endtask

    task automatic test_branch;
        step_t t[9] = '{
            '{NOP, 16'h0000, 0, 0, 0, 1, 2'd0, 2'b00, 16'h0000, 1, 0},
            '{BEQ, 16'h0040, 1, 0, 0, 0, 2'd0, 2'b10, 16'h0040, 1, 0},
            '{BEQ, 16'h0070, 0, 1, 0, 0, 2'd0, 2'b10, 16'h0041, 1, 0},
            '{BNE, 16'h0080, 0, 0, 0, 0, 2'd0, 2'b10, 16'h0080, 1, 0},
            '{BNE, 16'h0090, 1, 1, 0, 0, 2'd0, 2'b10, 16'h0081, 1, 0},
            '{BLT, 16'h0010, 0, 1, 0, 0, 2'd0, 2'b10, 16'h0010, 1, 0},
            '{BLT, 16'h0030, 1, 0, 0, 0, 2'd0, 2'b10, 16'h0011, 1, 0},
            '{JMP, 16'h0010, 0, 0, 0, 1, 2'd2, 2'b10, 16'h0010, 1, 0},
            '{NOP, 16'h0050, 1, 1, 0, 1, 2'd1, 2'b10, 16'h0011, 1, 0}
        };
        logic [19:0] e;
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            ntot++;
            if ({cm_obs, pc, running, done} !== e)
                $display("FAIL branch step %0d: got %h want %h", i, {cm_obs, pc, running, done}, e);
            else npass++;
        end
    endtask

    task automatic test_mem;
        step_t t[8] = '{
            '{JMP, 16'h0010, 0, 0, 0, 0, 2'd0, 2'b10, 16'h0010, 1, 0},
            '{STR, 16'h0000, 0, 0, 0, 0, 2'd0, 2'b01, 16'h0010, 1, 0},
            '{STR, 16'h0000, 0, 0, 0, 1, 2'd0, 2'b01, 16'h0010, 1, 0},
            '{STR, 16'h0000, 0, 0, 0, 0, 2'd0, 2'b01, 16'h0010, 1, 0},
            '{NOP, 16'h0000, 0, 0, 1, 0, 2'd0, 2'b11, 16'h0011, 1, 0},
            '{LB,  16'h0000, 0, 0, 1, 0, 2'd0, 2'b11, 16'h0012, 1, 0},
            '{LHB, 16'h0000, 0, 0, 1, 0, 2'd0, 2'b11, 16'h0013, 1, 0},
            '{NOP, 16'h0000, 0, 0, 1, 0, 2'd0, 2'b10, 16'h0014, 1, 0}
        };
        logic [19:0] e;
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            ntot++;
            if ({cm_obs, pc, running, done} !== e)
                $display("FAIL mem step %0d: got %h want %h", i, {cm_obs, pc, running, done}, e);
            else npass++;
        end
    endtask

    task automatic test_wrap;
        step_t t[3] = '{
            '{JMP, 16'hFFFF, 0, 0, 0, 0, 2'd0, 2'b10, 16'hFFFF, 1, 0},
            '{NOP, 16'h0000, 0, 0, 0, 0, 2'd0, 2'b10, 16'h0000, 1, 0},
            '{NOP, 16'h0000, 0, 0, 0, 0, 2'd0, 2'b10, 16'h0001, 1, 0}
        };
        logic [19:0] e;
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            ntot++;
            if ({cm_obs, pc, running, done} !== e)
                $display("FAIL wrap step %0d: got %h want %h", i, {cm_obs, pc, running, done}, e);
            else npass++;
        end
    endtask

    task automatic test_reset_memwait;
        step_t t[2] = '{
            '{LB, 16'h0000, 0, 0, 0, 0, 2'd0, 2'b01, 16'h0001, 1, 0},
            '{LB, 16'h0000, 0, 0, 0, 0, 2'd0, 2'b01, 16'h0001, 1, 0}
        };
        step_t s = '{NOP, 16'h0000, 0, 0, 0, 1, 2'd3, 2'b00, 16'h0000, 0, 0};
        logic [19:0] e;
        foreach (t[i]) begin
            drive(t[i]);
            e = sb.pop_front();
            ntot++;
            if ({cm_obs, pc, running, done} !== e)
                $display("FAIL memwait step %0d: got %h want %h", i, {cm_obs, pc, running, done}, e);
            else npass++;
        end
        reset = 1;
        tick();
        reset = 0;
        ntot++;
        if ({pc, running, mem_req, commit} !== 19'd0)
            $display("FAIL reset_memwait: got pc=%h run=%b mr=%b cm=%b want 0", pc, running, mem_req, commit);
        else npass++;
        drive(s);
        e = sb.pop_front();
        ntot++;
        if ({cm_obs, pc, running, done} !== e)
            $display("FAIL bad_sel: got %h want %h", {cm_obs, pc, running, done}, e);
        else npass++;
    endtask

    task automatic test_saturate;
        step_t s = '{NOP, 16'h0000, 0, 0, 0, 1, 2'd2, 2'b00, 16'h0005, 1, 0};
        logic [19:0] e;
        drive(s);
        e = sb.pop_front();
        ntot++;
        if ({cm_obs, pc, running, done} !== e)
            $display("FAIL launch2: got %h want %h", {cm_obs, pc, running, done}, e);
        else npass++;
        repeat (10) tick();
        ntot++;
        if (cycles !== 16'd10) $display("FAIL cycles10: got %h want 000a", cycles);
        else npass++;
        repeat (65530) tick();
        ntot++;
        if ({cycles, pc, running} !== {16'hFFFF, 16'h0009, 1'b1})
            $display("FAIL saturate: got cycles=%h pc=%h run=%b want ffff 0009 1", cycles, pc, running);
        else npass++;
        tick();
        ntot++;
        if (cycles !== 16'hFFFF) $display("FAIL saturate_hold: got %h want ffff", cycles);
        else npass++;
    endtask

    initial begin
        test_reset();
        test_program();
        test_branch();
        test_mem();
        test_wrap();
        test_reset_memwait();
        test_saturate();
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
